// File: rtl/hazard_scheduler.sv
// Hazard and stall scheduler for the 5-stage (F/D/E/M/W) pipelined core.
// Produces operand-forwarding selects, per-stage stall and flush controls for
// load-use, PC-write, taken-branch and multi-cycle data-memory hazards. Owns a
// data-memory wait-state FSM with a timeout, plus saturating stall/flush counters.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-low reset
//   Ra1D, Ra2D                  Decode source registers
//   Ra1E, Ra2E                  Execute source registers
//   WA3E, WA3M, WA3W            destination registers in E/M/W
//   RegWriteM, RegWriteW        register write enables in M/W
//   MemToRegE                   load in Execute
//   PCSrcD/E/M/W                instruction writes the PC, per stage
//   BranchTakenE                branch resolved taken in Execute
//   MemAccessM, MemReady        load/store in M, memory completes this cycle
//   ForwardAE, ForwardBE        00 register file, 01 ResultW, 10 ALUOutM
//   StallF/D/E/M                hold stage register
//   FlushD/E/W                  bubble stage register
//   MemTimeout                  sticky memory-timeout flag
//   StallCount, FlushCount      saturating event counters
module hazard_scheduler #(
  parameter int unsigned REG_BITS    = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_BITS-1:0]  Ra1D,
  input  logic [REG_BITS-1:0]  Ra2D,
  input  logic [REG_BITS-1:0]  Ra1E,
  input  logic [REG_BITS-1:0]  Ra2E,
  input  logic [REG_BITS-1:0]  WA3E,
  input  logic [REG_BITS-1:0]  WA3M,
  input  logic [REG_BITS-1:0]  WA3W,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemToRegE,
  input  logic                 PCSrcD,
  input  logic                 PCSrcE,
  input  logic                 PCSrcM,
  input  logic                 PCSrcW,
  input  logic                 BranchTakenE,
  input  logic                 MemAccessM,
  input  logic                 MemReady,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemTimeout,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int unsigned WcntBits = $clog2(MEM_TIMEOUT + 1);
  // wcnt holds the number of stall cycles already spent on the current access,
  // so the cycle seen with wcnt == MEM_TIMEOUT-1 is the last allowed stall.
  localparam logic [WcntBits-1:0] WcntLast = WcntBits'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRelease} memState_e;

  memState_e             stateQ, stateD;
  logic [WcntBits-1:0]   wcntQ, wcntD;
  logic                  memTimeoutQ, memTimeoutD;
  logic [CNT_WIDTH-1:0]  stallCntQ, stallCntD;
  logic [CNT_WIDTH-1:0]  flushCntQ, flushCntD;

  logic ldrStall, pcPend, memStall;

  // Forwarding: the younger result in M wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (WA3M == Ra1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (WA3W == Ra1E)) ForwardAE = 2'b01;
    if (RegWriteM && (WA3M == Ra2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (WA3W == Ra2E)) ForwardBE = 2'b01;
  end

  assign ldrStall = MemToRegE & ((WA3E == Ra1D) | (WA3E == Ra2D));
  assign pcPend   = PCSrcD | PCSrcE | PCSrcM;
  // The release cycle lets a timed-out access leave M regardless of MemReady.
  assign memStall = MemAccessM & ~MemReady & (stateQ != StRelease);

  // A memory stall freezes the whole front of the pipe; other hazards stay
  // visible on their inputs and are acted upon once the stall lifts.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldrStall | pcPend;
      StallD = ldrStall;
      FlushD = pcPend | PCSrcW | BranchTakenE;
      FlushE = ldrStall | BranchTakenE;
    end
  end

  always_comb begin
    stateD      = stateQ;
    wcntD       = wcntQ;
    memTimeoutD = memTimeoutQ;
    unique case (stateQ)
      StIdle: begin
        if (memStall) begin
          stateD = StWait;
          wcntD  = WcntBits'(1);
        end
      end
      StWait: begin
        if (!MemAccessM || MemReady) begin
          stateD = StIdle;
          wcntD  = '0;
        end else if (wcntQ == WcntLast) begin
          stateD      = StRelease;
          wcntD       = '0;
          memTimeoutD = 1'b1;
        end else begin
          wcntD = wcntQ + WcntBits'(1);
        end
      end
      StRelease: begin
        stateD = StIdle;
        wcntD  = '0;
      end
      default: begin
        stateD = StIdle;
        wcntD  = '0;
      end
    endcase
  end

  always_comb begin
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    if (StallF && (stallCntQ != '1)) stallCntD = stallCntQ + CNT_WIDTH'(1);
    if (FlushE && (flushCntQ != '1)) flushCntD = flushCntQ + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ      <= StIdle;
      wcntQ       <= '0;
      memTimeoutQ <= 1'b0;
      stallCntQ   <= '0;
      flushCntQ   <= '0;
    end else begin
      stateQ      <= stateD;
      wcntQ       <= wcntD;
      memTimeoutQ <= memTimeoutD;
      stallCntQ   <= stallCntD;
      flushCntQ   <= flushCntD;
    end
  end

  assign MemTimeout = memTimeoutQ;
  assign StallCount = stallCntQ;
  assign FlushCount = flushCntQ;

endmodule
